// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch engine that sits directly upstream of the instruction register. It
// holds the program counter, runs a req/ack read on program memory, and writes
// each fetched word into the IR through ir_data/ir_wr_en. The control unit
// starts fetches with fetch_start and redirects the PC with pc_load. The PC
// advances by PC_STEP on every completed fetch unless a redirect is pending.
//
// Ports
//   IR_clk       in   1       clock, rising edge
//   IR_rst       in   1       asynchronous, active-high reset
//   fetch_start  in   1       request one fetch at the current PC
//   pc_load      in   1       redirect the PC (jump/branch)
//   pc_load_val  in   ADDR_W  redirect target
//   mem_req      out  1       memory read request (registered)
//   mem_addr     out  ADDR_W  memory read address (registered, stable in REQ)
//   mem_ack      in   1       memory read data valid
//   mem_rdata    in   DATA_W  memory read data
//   ir_data      out  DATA_W  word for IR_in (registered)
//   ir_wr_en     out  1       one-cycle IR write strobe
//   pc_out       out  ADDR_W  current PC register
//   fetch_busy   out  1       high while a fetch is in REQ or WRITE
//   fetch_done   out  1       one-cycle pulse: the IR now holds the new word
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int unsigned           ADDR_W   = 16,
  parameter int unsigned           DATA_W   = 16,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0,
  parameter logic [ADDR_W-1:0]     PC_STEP  = ADDR_W'(1)
) (
  input  logic              IR_clk,
  input  logic              IR_rst,
  input  logic              fetch_start,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir_data,
  output logic              ir_wr_en,
  output logic [ADDR_W-1:0] pc_out,
  output logic              fetch_busy,
  output logic              fetch_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] pc, pc_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] ir_data_d;
  // A redirect that arrives while a fetch is in flight is parked here and
  // applied in WRITE instead of the normal increment.
  logic              pend_valid, pend_valid_d;
  logic [ADDR_W-1:0] pend_pc, pend_pc_d;

  // ---------------------------------------------------------------------------
  // Next-state and next-register logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d      = state;
    pc_d         = pc;
    mem_addr_d   = mem_addr;
    ir_data_d    = ir_data;
    pend_valid_d = pend_valid;
    pend_pc_d    = pend_pc;

    unique case (state)
      // DONE behaves exactly like IDLE for new requests, which is what lets a
      // held fetch_start issue back-to-back fetches every three cycles.
      S_IDLE, S_DONE: begin
        if (pc_load) begin
          pc_d = pc_load_val;
        end
        if (fetch_start) begin
          state_d    = S_REQ;
          // A simultaneous redirect is the address of this very fetch.
          mem_addr_d = pc_load ? pc_load_val : pc;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_REQ: begin
        if (pc_load) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = pc_load_val;   // last load wins
        end
        if (mem_req && mem_ack) begin
          ir_data_d = mem_rdata;
          state_d   = S_WRITE;
        end
      end

      S_WRITE: begin
        // A load arriving in this very cycle is newer than any pending one.
        if (pc_load) begin
          pc_d = pc_load_val;
        end else if (pend_valid) begin
          pc_d = pend_pc;
        end else begin
          pc_d = pc + PC_STEP;          // wraps modulo 2^ADDR_W
        end
        pend_valid_d = 1'b0;
        state_d      = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers. The strobes are decoded from the next state so
  // they are glitch-free flops aligned with the state they describe.
  // ---------------------------------------------------------------------------
  always_ff @(posedge IR_clk or posedge IR_rst) begin
    if (IR_rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      mem_addr   <= '0;
      ir_data    <= '0;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
      mem_req    <= 1'b0;
      ir_wr_en   <= 1'b0;
      fetch_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values; blocking here would chain registers within one clock.
      state      <= state_d;
      pc         <= pc_d;
      mem_addr   <= mem_addr_d;
      ir_data    <= ir_data_d;
      pend_valid <= pend_valid_d;
      pend_pc    <= pend_pc_d;
      mem_req    <= (state_d == S_REQ);
      ir_wr_en   <= (state_d == S_WRITE);
      fetch_done <= (state_d == S_DONE);
    end
  end

  assign pc_out     = pc;
  assign fetch_busy = (state == S_REQ) || (state == S_WRITE);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Self-checking bench for instruction_fetch_unit. A driver issues fetch
// transactions (with optional redirects, wait states, ignored strobes and
// stray acks) and also plays the program memory. For every fetch it pushes the
// expected {address, word} and the expected final PC into queues; a separate
// monitor pops and compares on ir_wr_en and fetch_done. The reference model is
// transaction level: the PC is a single variable updated by the redirect rules.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  logic        IR_clk;
  logic        IR_rst;
  logic        fetch_start;
  logic        pc_load;
  logic [15:0] pc_load_val;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] ir_data;
  logic        ir_wr_en;
  logic [15:0] pc_out;
  logic        fetch_busy;
  logic        fetch_done;

  instruction_fetch_unit dut (
    .IR_clk      (IR_clk),
    .IR_rst      (IR_rst),
    .fetch_start (fetch_start),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .ir_data     (ir_data),
    .ir_wr_en    (ir_wr_en),
    .pc_out      (pc_out),
    .fetch_busy  (fetch_busy),
    .fetch_done  (fetch_done)
  );

  initial IR_clk = 1'b0;
  always #5 IR_clk = ~IR_clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } fetch_t;

  fetch_t      exp_q[$];
  logic [15:0] pc_q[$];
  logic [15:0] mem [logic [15:0]];
  logic [15:0] model_pc;
  int          n_checks;
  int          n_fail;
  int          n_fetches;
  int          wr_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Program memory contents: explicit entries, otherwise a fixed hash.
  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 16'h9E37) ^ 16'h5A3C;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: compares whatever the DUT presents against the queued expectation.
  // ---------------------------------------------------------------------------
  always @(negedge IR_clk) begin
    if (!IR_rst) begin
      if (ir_wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected ir_wr_en", 32'd1, 32'd0);
        end else begin
          fetch_t e;
          e = exp_q.pop_front();
          check("ir_data", ir_data, e.data);
          check("mem_addr at write", mem_addr, e.addr);
          wr_seen++;
        end
      end
      if (fetch_done) begin
        if (pc_q.size() == 0) begin
          check("unexpected fetch_done", 32'd1, 32'd0);
        end else begin
          logic [15:0] p;
          p = pc_q.pop_front();
          check("pc_out after fetch", pc_out, p);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks. Called at a negedge; inputs set here are sampled at the next
  // rising edge. Each fetch returns at the negedge inside DONE.
  // ---------------------------------------------------------------------------
  task automatic idle(input int n, input bit allow_load);
    for (int i = 0; i < n; i++) begin
      fetch_start = 1'b0;
      pc_load     = allow_load ? 1'($urandom_range(0, 1)) : 1'b0;
      pc_load_val = 16'($urandom);
      if (pc_load) model_pc = pc_load_val;
      mem_ack     = 1'($urandom_range(0, 1));
      mem_rdata   = 16'($urandom);
      @(negedge IR_clk);
      check("idle mem_req", mem_req, 1'b0);
      check("idle ir_wr_en", ir_wr_en, 1'b0);
      check("idle fetch_busy", fetch_busy, 1'b0);
      check("idle pc_out", pc_out, model_pc);
    end
    pc_load = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic do_fetch(input bit ld, input logic [15:0] ld_val, input int wait_n,
                          input int n_req_loads, input logic [15:0] req_base,
                          input bit rand_req, input bit wr_ld, input logic [15:0] wr_val,
                          input bit hold_start);
    logic [15:0] addr;
    logic [15:0] exp_pc;
    logic [15:0] v;
    fetch_t      e;
    addr   = ld ? ld_val : model_pc;
    exp_pc = addr + 16'd1;
    e.addr = addr;
    e.data = mem_rd(addr);
    exp_q.push_back(e);

    fetch_start = 1'b1;
    pc_load     = ld;
    pc_load_val = ld_val;
    mem_ack     = 1'($urandom_range(0, 1));   // stray ack outside REQ
    mem_rdata   = 16'($urandom);
    @(negedge IR_clk);

    for (int i = 0; i <= wait_n; i++) begin
      check("mem_req in REQ", mem_req, 1'b1);
      check("fetch_busy in REQ", fetch_busy, 1'b1);
      check("mem_addr in REQ", mem_addr, addr);
      check("ir_wr_en in REQ", ir_wr_en, 1'b0);
      fetch_start = hold_start ? 1'b1 : 1'($urandom_range(0, 1));
      pc_load     = (i < n_req_loads);
      v           = rand_req ? 16'($urandom) : req_base + 16'(16 * i);
      pc_load_val = v;
      if (pc_load) exp_pc = v;
      mem_ack     = (i == wait_n);
      mem_rdata   = mem_ack ? mem_rd(mem_addr) : 16'($urandom);
      @(negedge IR_clk);
    end

    check("ir_wr_en in WRITE", ir_wr_en, 1'b1);
    check("fetch_busy in WRITE", fetch_busy, 1'b1);
    check("mem_req in WRITE", mem_req, 1'b0);
    fetch_start = hold_start ? 1'b1 : 1'($urandom_range(0, 1));
    pc_load     = wr_ld;
    pc_load_val = wr_val;
    if (wr_ld) exp_pc = wr_val;
    mem_ack     = 1'($urandom_range(0, 1));
    mem_rdata   = 16'($urandom);
    pc_q.push_back(exp_pc);
    @(negedge IR_clk);

    check("fetch_done in DONE", fetch_done, 1'b1);
    check("ir_wr_en in DONE", ir_wr_en, 1'b0);
    check("fetch_busy in DONE", fetch_busy, 1'b0);
    fetch_start = hold_start;
    pc_load     = 1'b0;
    mem_ack     = 1'b0;
    model_pc    = exp_pc;
    n_fetches++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0; n_fetches = 0; wr_seen = 0;
    model_pc    = 16'h0000;
    IR_rst      = 1'b0;
    fetch_start = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = '0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;

    // 1: reset asserted mid-clock clears everything immediately.
    #3 IR_rst = 1'b1;
    #1;
    check("reset mem_req", mem_req, 1'b0);
    check("reset mem_addr", mem_addr, 16'h0000);
    check("reset ir_data", ir_data, 16'h0000);
    check("reset ir_wr_en", ir_wr_en, 1'b0);
    check("reset fetch_done", fetch_done, 1'b0);
    check("reset fetch_busy", fetch_busy, 1'b0);
    check("reset pc_out", pc_out, 16'h0000);
    @(negedge IR_clk);
    @(negedge IR_clk);
    #2 IR_rst = 1'b0;
    @(negedge IR_clk);

    // 2: single fetch at PC 0 with two wait cycles.
    mem[16'h0000] = 16'hA5C3;
    do_fetch(1'b0, 16'h0, 2, 0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    check("single fetch ir_data", ir_data, 16'hA5C3);
    check("single fetch pc_out", pc_out, 16'h0001);
    idle(2, 1'b0);

    // 3: back-to-back fetches, fetch_start held, zero-wait ack.
    mem[16'h0000] = 16'h1111;
    mem[16'h0001] = 16'h2222;
    mem[16'h0002] = 16'h3333;
    mem[16'h0003] = 16'h4444;
    do_fetch(1'b1, 16'h0000, 0, 0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      do_fetch(1'b0, 16'h0, 0, 0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
    end
    check("back-to-back last word", ir_data, 16'h4444);
    check("back-to-back pc_out", pc_out, 16'h0004);
    idle(1, 1'b0);

    // 4: redirects with fetch_start, during REQ, and in the WRITE cycle.
    do_fetch(1'b1, 16'h0040, 1, 0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    check("redirect with start pc", pc_out, 16'h0041);
    do_fetch(1'b0, 16'h0, 2, 2, 16'h0080, 1'b0, 1'b0, 16'h0, 1'b0);
    check("redirect in REQ pc", pc_out, 16'h0090);
    do_fetch(1'b0, 16'h0, 0, 1, 16'h0200, 1'b0, 1'b1, 16'h0300, 1'b0);
    check("redirect in WRITE pc", pc_out, 16'h0300);
    idle(1, 1'b0);

    // 5: PC wrap.
    do_fetch(1'b1, 16'hFFFF, 1, 0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    check("wrap pc_out", pc_out, 16'h0000);
    idle(1, 1'b0);

    // 6: reset during REQ aborts the fetch; the next fetch starts at RESET_PC.
    pc_load = 1'b1; pc_load_val = 16'h1234; model_pc = 16'h1234;
    @(negedge IR_clk);
    pc_load = 1'b0;
    fetch_start = 1'b1;
    @(negedge IR_clk);
    fetch_start = 1'b0;
    check("pre-reset mem_req", mem_req, 1'b1);
    #2 IR_rst = 1'b1;
    exp_q.delete();
    pc_q.delete();
    model_pc = 16'h0000;
    #1;
    check("reset in REQ mem_req", mem_req, 1'b0);
    check("reset in REQ fetch_busy", fetch_busy, 1'b0);
    check("reset in REQ pc_out", pc_out, 16'h0000);
    @(negedge IR_clk);
    #2 IR_rst = 1'b0;
    @(negedge IR_clk);
    idle(2, 1'b0);
    do_fetch(1'b0, 16'h0, 1, 0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    check("post-reset pc_out", pc_out, 16'h0001);

    // Randomised traffic.
    for (int n = 0; n < 150; n++) begin
      int wn;
      idle($urandom_range(0, 2), 1'b1);
      wn = $urandom_range(0, 3);
      do_fetch(1'($urandom_range(0, 1)), 16'($urandom), wn,
               $urandom_range(0, wn + 1), 16'h0, 1'b1,
               ($urandom_range(0, 3) == 0), 16'($urandom), 1'b0);
    end
    idle(3, 1'b0);

    check("write strobes seen", wr_seen, n_fetches);
    check("data queue drained", exp_q.size(), 0);
    check("pc queue drained", pc_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
